// File: rtl/branch_recovery_ctrl_pkg.sv
// Shared widths, FSM encoding and queue entry layout for the branch recovery controller.
package branch_recovery_ctrl_pkg;

   localparam int WORD_LEN = 32;

   // RUN = normal speculation, FLUSH = squashing wrong-path fetch after a mispredict.
   typedef enum logic {
      ST_RUN   = 1'b0,
      ST_FLUSH = 1'b1
   } state_e;

   // One in-flight branch as predicted by IF.
   typedef struct packed {
      logic [WORD_LEN-1:0] pc;
      logic                taken;
      logic [WORD_LEN-1:0] target;
   } bp_entry_t;

   localparam int ENTRY_W = $bits(bp_entry_t);

   // Fall-through address of a branch; wraps at 32 bits.
   function automatic logic [WORD_LEN-1:0] seq_pc(input logic [WORD_LEN-1:0] pc);
      return pc + WORD_LEN'(4);
   endfunction

endpackage

// File: rtl/bp_inflight_fifo.sv
// In-order circular queue of predicted branches. Clear has priority over push/pop.
// Interface contract: push is accepted when not full or when a pop happens in the
// same cycle; pop is accepted only when not empty; rejected requests have no effect.
module bp_inflight_fifo #(
   parameter int DEPTH    = 4,
   parameter int PTR_BITS = 2,
   parameter int W        = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  logic              pop,
   input  logic              clear,
   input  logic [W-1:0]      wr_data,
   output logic              full,
   output logic              empty,
   output logic [PTR_BITS:0] occupancy,
   output logic [W-1:0]      head_data
);

   logic [W-1:0]        mem_q [DEPTH];
   logic [PTR_BITS-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_BITS-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_BITS:0]   occ_q, occ_d;
   logic                do_push;
   logic                do_pop;

   assign full      = (occ_q == (PTR_BITS+1)'(DEPTH));
   assign empty     = (occ_q == '0);
   assign occupancy = occ_q;
   assign head_data = mem_q[rd_ptr_q];
   assign do_push   = push && (!full || pop);
   assign do_pop    = pop && !empty;

   // Next pointer / occupancy values; clear resets the queue and drops any push.
   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      occ_d    = occ_q;
      if (clear) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         occ_d    = '0;
      end else begin
         if (do_push) wr_ptr_d = wr_ptr_q + PTR_BITS'(1);
         if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_BITS'(1);
         case ({do_push, do_pop})
            2'b10:   occ_d = occ_q + (PTR_BITS+1)'(1);
            2'b01:   occ_d = occ_q - (PTR_BITS+1)'(1);
            default: occ_d = occ_q;
         endcase
      end
   end

   // Pointer and occupancy registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         occ_q    <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         occ_q    <= occ_d;
      end
   end

   // Entry storage; contents are only meaningful between rd and wr pointers.
   always_ff @(posedge clk) begin
      if (do_push && !clear) mem_q[wr_ptr_q] <= wr_data;
   end

endmodule

// File: rtl/branch_recovery_ctrl.sv
// Tracks predicted branches, matches ID resolutions against the oldest one, trains
// the predictor and runs the flush/redirect sequence on a misprediction.
module branch_recovery_ctrl
   import branch_recovery_ctrl_pkg::*;
#(
   parameter int DEPTH        = 4,
   parameter int PTR_BITS     = 2,
   parameter int FLUSH_CYCLES = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                pred_valid,
   input  logic [WORD_LEN-1:0] pred_pc,
   input  logic                pred_taken,
   input  logic [WORD_LEN-1:0] pred_target,
   input  logic                res_valid,
   input  logic                res_taken,
   input  logic [WORD_LEN-1:0] res_target,
   output logic                bp_update_en,
   output logic [WORD_LEN-1:0] bp_update_pc,
   output logic                bp_actual_taken,
   output logic                flush,
   output logic                redirect_valid,
   output logic [WORD_LEN-1:0] redirect_pc,
   output logic                stall_fetch,
   output logic [PTR_BITS:0]   occupancy,
   output logic                orphan_err
);

   localparam int CNT_W = $clog2(FLUSH_CYCLES + 1);

   state_e              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                upd_en_q, upd_en_d;
   logic [WORD_LEN-1:0] upd_pc_q, upd_pc_d;
   logic                act_q, act_d;
   logic                rdv_q, rdv_d;
   logic [WORD_LEN-1:0] rpc_q, rpc_d;
   logic                orphan_q, orphan_d;

   logic                in_run;
   logic                fifo_push, fifo_pop, fifo_clear;
   logic                fifo_full, fifo_empty;
   logic [PTR_BITS:0]   fifo_occ;
   logic [ENTRY_W-1:0]  head_raw;
   bp_entry_t           head;
   bp_entry_t           new_entry;
   logic                mispredict;
   logic                orphan_hit;

   assign in_run     = (state_q == ST_RUN);
   assign new_entry  = '{pc: pred_pc, taken: pred_taken, target: pred_target};
   assign head       = bp_entry_t'(head_raw);
   assign fifo_push  = pred_valid && in_run;
   assign fifo_pop   = res_valid && in_run && !fifo_empty;
   assign orphan_hit = res_valid && in_run && fifo_empty;
   assign mispredict = fifo_pop &&
                       ((res_taken != head.taken) || (res_taken && (res_target != head.target)));
   assign fifo_clear = mispredict;

   bp_inflight_fifo #(
      .DEPTH    (DEPTH),
      .PTR_BITS (PTR_BITS),
      .W        (ENTRY_W)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (fifo_push),
      .pop       (fifo_pop),
      .clear     (fifo_clear),
      .wr_data   (new_entry),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .occupancy (fifo_occ),
      .head_data (head_raw)
   );

   assign stall_fetch     = fifo_full;
   assign occupancy       = fifo_occ;
   assign flush           = (state_q == ST_FLUSH);
   assign bp_update_en    = upd_en_q;
   assign bp_update_pc    = upd_pc_q;
   assign bp_actual_taken = act_q;
   assign redirect_valid  = rdv_q;
   assign redirect_pc     = rpc_q;
   assign orphan_err      = orphan_q;

   // Next state, flush counter, one-cycle update/redirect pulses and sticky orphan flag.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      upd_en_d = fifo_pop;
      upd_pc_d = fifo_pop ? head.pc : '0;
      act_d    = fifo_pop && res_taken;
      rdv_d    = mispredict;
      rpc_d    = '0;
      orphan_d = orphan_q || orphan_hit;
      if (mispredict) rpc_d = res_taken ? res_target : seq_pc(head.pc);
      case (state_q)
         ST_RUN: begin
            if (mispredict) begin
               state_d = ST_FLUSH;
               cnt_d   = CNT_W'(FLUSH_CYCLES);
            end
         end
         ST_FLUSH: begin
            if (cnt_q == CNT_W'(1)) begin
               state_d = ST_RUN;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         default: begin
            state_d = ST_RUN;
            cnt_d   = '0;
         end
      endcase
   end

   // Control and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_RUN;
         cnt_q    <= '0;
         upd_en_q <= 1'b0;
         upd_pc_q <= '0;
         act_q    <= 1'b0;
         rdv_q    <= 1'b0;
         rpc_q    <= '0;
         orphan_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         upd_en_q <= upd_en_d;
         upd_pc_q <= upd_pc_d;
         act_q    <= act_d;
         rdv_q    <= rdv_d;
         rpc_q    <= rpc_d;
         orphan_q <= orphan_d;
      end
   end

endmodule

// File: tb/tb_branch_recovery_ctrl.sv
// Directed vector table plus hand-written multi-cycle sequences for branch_recovery_ctrl.
module tb_branch_recovery_ctrl;

   typedef struct {
      logic        rst;
      logic        pv;
      logic [31:0] ppc;
      logic        pt;
      logic [31:0] ptgt;
      logic        rv;
      logic        rt;
      logic [31:0] rtgt;
      logic        e_upd;
      logic [31:0] e_upc;
      logic        e_act;
      logic        e_flush;
      logic        e_rdv;
      logic [31:0] e_rpc;
      logic        e_stall;
      logic [2:0]  e_occ;
      logic        e_orph;
   } vec_t;

   logic        clk;
   logic        rst;
   logic        pred_valid;
   logic [31:0] pred_pc;
   logic        pred_taken;
   logic [31:0] pred_target;
   logic        res_valid;
   logic        res_taken;
   logic [31:0] res_target;
   logic        bp_update_en;
   logic [31:0] bp_update_pc;
   logic        bp_actual_taken;
   logic        flush;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        stall_fetch;
   logic [2:0]  occupancy;
   logic        orphan_err;

   int          pass_cnt = 0;
   int          total_cnt = 0;
   vec_t        tbl[$];
   logic [31:0] exp_q[$];

   branch_recovery_ctrl dut (
      .clk             (clk),
      .rst             (rst),
      .pred_valid      (pred_valid),
      .pred_pc         (pred_pc),
      .pred_taken      (pred_taken),
      .pred_target     (pred_target),
      .res_valid       (res_valid),
      .res_taken       (res_taken),
      .res_target      (res_target),
      .bp_update_en    (bp_update_en),
      .bp_update_pc    (bp_update_pc),
      .bp_actual_taken (bp_actual_taken),
      .flush           (flush),
      .redirect_valid  (redirect_valid),
      .redirect_pc     (redirect_pc),
      .stall_fetch     (stall_fetch),
      .occupancy       (occupancy),
      .orphan_err      (orphan_err)
   );

   // Clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      else pass_cnt++;
   endtask

   task automatic drive(input logic r, input logic pv, input logic [31:0] ppc, input logic pt,
                        input logic [31:0] ptgt, input logic rv, input logic rt, input logic [31:0] rtgt);
      @(negedge clk);
      rst = r; pred_valid = pv; pred_pc = ppc; pred_taken = pt; pred_target = ptgt;
      res_valid = rv; res_taken = rt; res_target = rtgt;
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      drive(0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      int flush_cnt;
      int rdv_cnt;
      logic [31:0] first_rpc;
      logic [31:0] exp_pc;

      rst = 1'b1; pred_valid = 0; pred_pc = 0; pred_taken = 0; pred_target = 0;
      res_valid = 0; res_taken = 0; res_target = 0;

      //                 rst pv ppc     pt ptgt    rv rt rtgt      upd upc     act fl rdv rpc     st occ orph
      tbl.push_back(vec_t'{1, 0, 32'h0,   0, 32'h0,   0, 0, 32'h0,   0, 32'h0,   0, 0, 0, 32'h0,   0, 3'd0, 0}); // 0 reset
      tbl.push_back(vec_t'{0, 0, 32'h0,   0, 32'h0,   0, 0, 32'h0,   0, 32'h0,   0, 0, 0, 32'h0,   0, 3'd0, 0}); // 1 idle
      tbl.push_back(vec_t'{0, 1, 32'h40,  1, 32'h80,  0, 0, 32'h0,   0, 32'h0,   0, 0, 0, 32'h0,   0, 3'd1, 0}); // 2 push
      tbl.push_back(vec_t'{0, 0, 32'h0,   0, 32'h0,   1, 1, 32'h80,  1, 32'h40,  1, 0, 0, 32'h0,   0, 3'd0, 0}); // 3 correct
      tbl.push_back(vec_t'{0, 0, 32'h0,   0, 32'h0,   0, 0, 32'h0,   0, 32'h0,   0, 0, 0, 32'h0,   0, 3'd0, 0}); // 4 pulse ends
      tbl.push_back(vec_t'{0, 1, 32'h100, 0, 32'h0,   0, 0, 32'h0,   0, 32'h0,   0, 0, 0, 32'h0,   0, 3'd1, 0}); // 5
      tbl.push_back(vec_t'{0, 0, 32'h0,   0, 32'h0,   1, 1, 32'h200, 1, 32'h100, 1, 1, 1, 32'h200, 0, 3'd0, 0}); // 6 dir mispredict
      tbl.push_back(vec_t'{0, 0, 32'h0,   0, 32'h0,   0, 0, 32'h0,   0, 32'h0,   0, 1, 0, 32'h0,   0, 3'd0, 0}); // 7 flush 2nd
      tbl.push_back(vec_t'{0, 0, 32'h0,   0, 32'h0,   0, 0, 32'h0,   0, 32'h0,   0, 0, 0, 32'h0,   0, 3'd0, 0}); // 8 back to RUN
      tbl.push_back(vec_t'{0, 1, 32'h1C,  1, 32'h40,  0, 0, 32'h0,   0, 32'h0,   0, 0, 0, 32'h0,   0, 3'd1, 0}); // 9
      tbl.push_back(vec_t'{0, 0, 32'h0,   0, 32'h0,   1, 0, 32'h0,   1, 32'h1C,  0, 1, 1, 32'h20,  0, 3'd0, 0}); // 10 taken->not
      tbl.push_back(vec_t'{0, 1, 32'h50,  0, 32'h0,   1, 1, 32'h0,   0, 32'h0,   0, 1, 0, 32'h0,   0, 3'd0, 0}); // 11 ignored
      tbl.push_back(vec_t'{0, 1, 32'h50,  0, 32'h0,   1, 1, 32'h0,   0, 32'h0,   0, 0, 0, 32'h0,   0, 3'd0, 0}); // 12 ignored
      tbl.push_back(vec_t'{0, 0, 32'h0,   0, 32'h0,   0, 0, 32'h0,   0, 32'h0,   0, 0, 0, 32'h0,   0, 3'd0, 0}); // 13
      tbl.push_back(vec_t'{0, 1, 32'h0,   0, 32'h0,   0, 0, 32'h0,   0, 32'h0,   0, 0, 0, 32'h0,   0, 3'd1, 0}); // 14
      tbl.push_back(vec_t'{0, 1, 32'h4,   0, 32'h0,   0, 0, 32'h0,   0, 32'h0,   0, 0, 0, 32'h0,   0, 3'd2, 0}); // 15
      tbl.push_back(vec_t'{0, 1, 32'h8,   0, 32'h0,   0, 0, 32'h0,   0, 32'h0,   0, 0, 0, 32'h0,   0, 3'd3, 0}); // 16
      tbl.push_back(vec_t'{0, 1, 32'hC,   0, 32'h0,   0, 0, 32'h0,   0, 32'h0,   0, 0, 0, 32'h0,   1, 3'd4, 0}); // 17 full
      tbl.push_back(vec_t'{0, 1, 32'h10,  0, 32'h0,   0, 0, 32'h0,   0, 32'h0,   0, 0, 0, 32'h0,   1, 3'd4, 0}); // 18 dropped
      tbl.push_back(vec_t'{0, 1, 32'h14,  0, 32'h0,   1, 0, 32'h0,   1, 32'h0,   0, 0, 0, 32'h0,   1, 3'd4, 0}); // 19 push+pop
      tbl.push_back(vec_t'{0, 0, 32'h0,   0, 32'h0,   1, 0, 32'h0,   1, 32'h4,   0, 0, 0, 32'h0,   0, 3'd3, 0}); // 20
      tbl.push_back(vec_t'{0, 0, 32'h0,   0, 32'h0,   1, 0, 32'h0,   1, 32'h8,   0, 0, 0, 32'h0,   0, 3'd2, 0}); // 21
      tbl.push_back(vec_t'{0, 0, 32'h0,   0, 32'h0,   1, 0, 32'h0,   1, 32'hC,   0, 0, 0, 32'h0,   0, 3'd1, 0}); // 22
      tbl.push_back(vec_t'{0, 0, 32'h0,   0, 32'h0,   1, 0, 32'h0,   1, 32'h14,  0, 0, 0, 32'h0,   0, 3'd0, 0}); // 23 wrapped entry
      tbl.push_back(vec_t'{0, 0, 32'h0,   0, 32'h0,   1, 0, 32'h0,   0, 32'h0,   0, 0, 0, 32'h0,   0, 3'd0, 1}); // 24 orphan
      tbl.push_back(vec_t'{0, 0, 32'h0,   0, 32'h0,   0, 0, 32'h0,   0, 32'h0,   0, 0, 0, 32'h0,   0, 3'd0, 1}); // 25 sticky
      tbl.push_back(vec_t'{0, 1, 32'h200, 1, 32'h300, 0, 0, 32'h0,   0, 32'h0,   0, 0, 0, 32'h0,   0, 3'd1, 1}); // 26
      tbl.push_back(vec_t'{0, 0, 32'h0,   0, 32'h0,   1, 1, 32'h304, 1, 32'h200, 1, 1, 1, 32'h304, 0, 3'd0, 1}); // 27 target mispredict
      tbl.push_back(vec_t'{1, 0, 32'h0,   0, 32'h0,   0, 0, 32'h0,   0, 32'h0,   0, 0, 0, 32'h0,   0, 3'd0, 0}); // 28 rst mid-FLUSH
      tbl.push_back(vec_t'{0, 0, 32'h0,   0, 32'h0,   0, 0, 32'h0,   0, 32'h0,   0, 0, 0, 32'h0,   0, 3'd0, 0}); // 29
      tbl.push_back(vec_t'{0, 1, 32'h60,  0, 32'h0,   0, 0, 32'h0,   0, 32'h0,   0, 0, 0, 32'h0,   0, 3'd1, 0}); // 30
      tbl.push_back(vec_t'{0, 1, 32'h64,  0, 32'h0,   1, 1, 32'h90,  1, 32'h60,  1, 1, 1, 32'h90,  0, 3'd0, 0}); // 31 push discarded
      tbl.push_back(vec_t'{0, 0, 32'h0,   0, 32'h0,   0, 0, 32'h0,   0, 32'h0,   0, 1, 0, 32'h0,   0, 3'd0, 0}); // 32
      tbl.push_back(vec_t'{0, 0, 32'h0,   0, 32'h0,   0, 0, 32'h0,   0, 32'h0,   0, 0, 0, 32'h0,   0, 3'd0, 0}); // 33

      foreach (tbl[i]) begin
         drive(tbl[i].rst, tbl[i].pv, tbl[i].ppc, tbl[i].pt, tbl[i].ptgt, tbl[i].rv, tbl[i].rt, tbl[i].rtgt);
         chk($sformatf("v%0d update_en", i), 32'(bp_update_en), 32'(tbl[i].e_upd));
         chk($sformatf("v%0d update_pc", i), bp_update_pc, tbl[i].e_upc);
         chk($sformatf("v%0d actual_taken", i), 32'(bp_actual_taken), 32'(tbl[i].e_act));
         chk($sformatf("v%0d flush", i), 32'(flush), 32'(tbl[i].e_flush));
         chk($sformatf("v%0d redirect_valid", i), 32'(redirect_valid), 32'(tbl[i].e_rdv));
         chk($sformatf("v%0d redirect_pc", i), redirect_pc, tbl[i].e_rpc);
         chk($sformatf("v%0d stall_fetch", i), 32'(stall_fetch), 32'(tbl[i].e_stall));
         chk($sformatf("v%0d occupancy", i), 32'(occupancy), 32'(tbl[i].e_occ));
         chk($sformatf("v%0d orphan_err", i), 32'(orphan_err), 32'(tbl[i].e_orph));
      end

      // Sequence: flush window length and single redirect pulse over a bounded window.
      drive(0, 1, 32'h80, 0, 32'h0, 0, 0, 32'h0);
      drive(0, 0, 32'h0, 0, 32'h0, 1, 1, 32'hA0);
      flush_cnt = 0;
      rdv_cnt   = 0;
      first_rpc = redirect_pc;
      for (int k = 0; k < 8; k++) begin
         if (flush) flush_cnt++;
         if (redirect_valid) rdv_cnt++;
         idle();
      end
      chk("seq flush_cycles", 32'(flush_cnt), 32'd2);
      chk("seq redirect_pulses", 32'(rdv_cnt), 32'd1);
      chk("seq redirect_pc", first_rpc, 32'hA0);

      // Sequence: back-to-back correct predictions train the predictor in order.
      for (int k = 0; k < 3; k++) begin
         drive(0, 1, 32'h300 + 32'(4 * k), 0, 32'h0, 0, 0, 32'h0);
         exp_q.push_back(32'h300 + 32'(4 * k));
      end
      chk("seq occupancy_3", 32'(occupancy), 32'd3);
      for (int k = 0; k < 3; k++) begin
         drive(0, 0, 32'h0, 0, 32'h0, 1, 0, 32'h0);
         exp_pc = exp_q.pop_front();
         chk($sformatf("seq update_en_%0d", k), 32'(bp_update_en), 32'd1);
         chk($sformatf("seq update_pc_%0d", k), bp_update_pc, exp_pc);
         chk($sformatf("seq no_flush_%0d", k), 32'(flush), 32'd0);
      end
      chk("seq occupancy_0", 32'(occupancy), 32'd0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
